// File: rtl/aes_text_out_unloader.sv
// Captures the 128-bit cipher result on done and streams it out as WORD_W-bit words,
// most-significant word first, over a valid/ready handshake.
module aes_text_out_unloader #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [127:0]      text_out,
  output logic              m_valid,
  output logic [WORD_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              overrun,
  input  logic              clr_ovr
);

  localparam int unsigned NWORDS  = 128 / WORD_W;
  localparam int unsigned IdxW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NWORDS - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e          state_q, state_d;
  logic [127:0]    buf_q, buf_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            ovr_q, ovr_d;

  logic            hs;
  logic            at_last;
  logic            ovr_set;
  logic [7:0]      shamt;
  logic [127:0]    shifted;

  // Outputs depend only on registered state; m_ready never reaches them combinationally.
  always_comb begin
    m_valid = (state_q == StSend);
    busy    = m_valid;
    at_last = (idx_q == LastIdx);
    shamt   = 8'(idx_q) * 8'(WORD_W);
    shifted = buf_q << shamt;
    m_data  = m_valid ? shifted[127 -: WORD_W] : '0;
    m_last  = m_valid && at_last;
    overrun = ovr_q;
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    ovr_set = 1'b0;
    hs      = m_valid && m_ready;
    unique case (state_q)
      StIdle: begin
        if (done) begin
          buf_d   = text_out;
          idx_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (hs && !at_last) begin
          idx_d = idx_q + 1'b1;
        end else if (hs && at_last) begin
          if (done) begin
            buf_d = text_out;
            idx_d = '0;
          end else begin
            state_d = StIdle;
          end
        end
        // Only the final-word handshake can absorb a new block.
        if (done && !(hs && at_last)) begin
          ovr_set = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    ovr_d = ovr_set ? 1'b1 : (clr_ovr ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      buf_q   <= '0;
      idx_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      ovr_q   <= ovr_d;
    end
  end

endmodule
